// File: rtl/accumulator_4b_pkg.sv
// Shared types and widths for the 4-bit group accumulator.
package accumulator_4b_pkg;

   localparam int DATA_W = 4;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

endpackage : accumulator_4b_pkg

// File: rtl/accumulator_4b_adder.sv
// 4-bit unsigned adder without carry-out; the sum wraps modulo 16.
module accumulator_4b_adder
   import accumulator_4b_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);

   // Plain modulo-2^DATA_W addition; the carry is intentionally dropped.
   assign sum = a + b;

endmodule : accumulator_4b_adder

// File: rtl/accumulator_4b.sv
// Sums groups of NUM_OPERANDS 4-bit operands (mod 16) received over a val/rdy
// input, and presents each group sum plus a sticky wrap flag over a val/rdy output.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ACCUM | accepting operands; acc/count/wrap track the partial group
// DONE  | group complete; result held on the output until out_rdy
module accumulator_4b
   import accumulator_4b_pkg::*;
#(
   parameter int NUM_OPERANDS = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_val,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_wrap
);

   localparam int                CNT_W = $clog2(NUM_OPERANDS);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_OPERANDS - 1);

   state_t              state;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   sum;
   logic [CNT_W-1:0]    count;
   logic                wrap;

   accumulator_4b_adder u_adder (
      .a   (acc),
      .b   (in_data),
      .sum (sum)
   );

   // Group sequencing: accumulate operands, then hold the result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               // in_rdy is 1 throughout ACCUM, so in_val alone marks a transfer.
               if (in_val) begin
                  acc   <= sum;
                  count <= count + CNT_W'(1);
                  // The adder has no carry-out; a result smaller than acc means it wrapped.
                  wrap  <= wrap | (sum < acc);
                  if (count == LAST) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_rdy) begin
                  acc   <= '0;
                  count <= '0;
                  wrap  <= 1'b0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   // Handshake flags come from state only; in_rdy also drops at once while rst is high.
   assign in_rdy   = (state == ACCUM) && !rst;
   assign out_val  = (state == DONE);
   assign out_sum  = out_val ? acc : '0;
   assign out_wrap = out_val & wrap;

endmodule : accumulator_4b

// File: tb/tb_accumulator_4b.sv
// Bench for accumulator_4b: directed scenarios plus randomized traffic, all
// checked every cycle against a running-total model of the group.
module tb_accumulator_4b;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_val;
   logic       in_rdy;
   logic [3:0] in_data;
   logic       out_val;
   logic       out_rdy;
   logic [3:0] out_sum;
   logic       out_wrap;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Model: operands accepted so far, their plain integer total, result pending.
   int m_cnt   = 0;
   int m_total = 0;
   bit m_done  = 1'b0;

   accumulator_4b #(.NUM_OPERANDS(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_sum  (out_sum),
      .out_wrap (out_wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string name, input logic rdy, input logic val,
                             input logic [3:0] sum, input logic wrap);
      chk({name, ".in_rdy"},   32'(in_rdy),   32'(rdy));
      chk({name, ".out_val"},  32'(out_val),  32'(val));
      chk({name, ".out_sum"},  32'(out_sum),  32'(sum));
      chk({name, ".out_wrap"}, 32'(out_wrap), 32'(wrap));
   endtask

   // Drive one cycle of inputs, away from the rising edge.
   task automatic step(input logic v, input logic [3:0] d, input logic r);
      @(negedge clk);
      in_val  = v;
      in_data = d;
      out_rdy = r;
   endtask

   // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
   task automatic rst_pulse(input string name);
      #2 rst = 1'b1;
      #1 expect_out(name, 1'b0, 1'b0, 4'd0, 1'b0);
      #1 rst = 1'b0;
   endtask

   // Reference behaviour: a group's sum is its total mod 16, and it wrapped
   // iff the running total ever reached 16, i.e. iff the final total is >= 16.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt   = 0;
         m_total = 0;
         m_done  = 1'b0;
      end else if (m_done) begin
         if (out_rdy) begin
            m_cnt   = 0;
            m_total = 0;
            m_done  = 1'b0;
         end
      end else if (in_val) begin
         m_total += int'(in_data);
         m_cnt++;
         if (m_cnt == N) m_done = 1'b1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         expect_out("model", !m_done, m_done,
                    m_done ? 4'(m_total % 16) : 4'd0,
                    m_done ? (m_total >= 16) : 1'b0);
      end
   end

   logic [3:0] t6_data [10] = '{4'd15, 4'd1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0};
   int pulse_idx [$];

   initial begin
      rst     = 1'b1;
      in_val  = 1'b0;
      in_data = 4'd0;
      out_rdy = 1'b0;
      #1 expect_out("reset", 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // 1: basic sum
      step(1, 4'd1, 1); step(1, 4'd2, 1); step(1, 4'd3, 1); step(1, 4'd4, 1);
      step(0, 4'd0, 1);
      expect_out("basic_done", 1'b0, 1'b1, 4'd10, 1'b0);
      step(0, 4'd0, 1);
      expect_out("basic_after", 1'b1, 1'b0, 4'd0, 1'b0);

      // 2: wrap, then the flag clears for the next group
      step(1, 4'd8, 1); step(1, 4'd8, 1); step(1, 4'd8, 1); step(1, 4'd9, 1);
      step(0, 4'd0, 1);
      expect_out("wrap_done", 1'b0, 1'b1, 4'd1, 1'b1);
      step(1, 4'd0, 1); step(1, 4'd0, 1); step(1, 4'd0, 1); step(1, 4'd0, 1);
      step(0, 4'd0, 1);
      expect_out("zero_done", 1'b0, 1'b1, 4'd0, 1'b0);

      // 3: backpressure with a blocked operand pending upstream
      step(1, 4'd5, 0); step(1, 4'd7, 0); step(1, 4'd0, 0); step(1, 4'd3, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 4'd6, 0);
         expect_out("bp_hold", 1'b0, 1'b1, 4'd15, 1'b0);
      end
      step(0, 4'd0, 1);
      expect_out("bp_release", 1'b0, 1'b1, 4'd15, 1'b0);
      step(0, 4'd0, 0);
      expect_out("bp_after", 1'b1, 1'b0, 4'd0, 1'b0);

      // 4: bubbles; data during in_val=0 must be ignored
      step(1, 4'd2, 1); step(0, 4'd9, 1); step(1, 4'd3, 1); step(0, 4'd9, 1);
      step(1, 4'd4, 1); step(1, 4'd5, 1);
      expect_out("bubble_partial", 1'b1, 1'b0, 4'd0, 1'b0);
      step(0, 4'd0, 1);
      expect_out("bubble_done", 1'b0, 1'b1, 4'd14, 1'b0);

      // 5: reset mid-group discards the partial sum
      step(0, 4'd0, 0);
      step(1, 4'd7, 0); step(1, 4'd7, 0); step(0, 4'd0, 0);
      rst_pulse("midgroup_rst");
      step(1, 4'd1, 1); step(1, 4'd1, 1); step(1, 4'd1, 1); step(1, 4'd1, 1);
      step(0, 4'd0, 1);
      expect_out("post_rst_done", 1'b0, 1'b1, 4'd4, 1'b0);

      // 6: back-to-back groups at full rate
      step(0, 4'd0, 1);
      for (int k = 0; k < 10; k++) begin
         step(k < 9, t6_data[k], 1);
         if (out_val) pulse_idx.push_back(k);
         if (k == 4) expect_out("b2b_first", 1'b0, 1'b1, 4'd0, 1'b1);
         if (k == 9) expect_out("b2b_second", 1'b0, 1'b1, 4'd8, 1'b0);
      end
      chk("b2b_pulses", 32'(pulse_idx.size()), 32'd2);
      if (pulse_idx.size() == 2) chk("b2b_spacing", 32'(pulse_idx[1] - pulse_idx[0]), 32'd5);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 199) == 0) rst_pulse("rand_rst");
      end

      step(0, 4'd0, 0);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_accumulator_4b

// File: doc/accumulator_4b.md
Name: accumulator_4b

Overview:
- Sequential stage that sits directly downstream of the Adder_4b datapath.
- Accepts a stream of 4-bit operands over a val/rdy handshake and sums a fixed group of NUM_OPERANDS of them, modulo 16.
- Presents the 4-bit group sum, plus a wrap-around flag, over an output val/rdy handshake.
- Serves as the reduction stage for blocks that need a sum of more than two operands.

Parameters:
NUM_OPERANDS, 4, number of operands summed per group; legal range 2..16

Ports:
clk       input   1  clock; all state updates on rising edge
rst       input   1  reset, asynchronous, active-high
in_val    input   1  operand valid
in_rdy    output  1  block can accept an operand this cycle
in_data   input   4  operand, unsigned
out_val   output  1  group result valid
out_rdy   input   1  consumer accepts result this cycle
out_sum   output  4  group sum modulo 16
out_wrap  output  1  1 if any addition in the group wrapped past 15

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While rst=1: state=ACCUM, acc=0, count=0, wrap=0.
  - Outputs during reset: in_rdy=0, out_val=0, out_sum=0, out_wrap=0.
  - Asserting rst mid-group discards the partial sum immediately; no output is produced for that group.
- State machine, two states:
  - ACCUM:
    - in_rdy=1, out_val=0.
    - An operand transfers when in_val & in_rdy. On transfer: acc <= acc + in_data (4-bit, via Adder_4b), count <= count+1.
    - wrap <= wrap | (sum < acc). This unsigned compare detects the lost carry, since Adder_4b has no carry-out.
    - A transfer with count == NUM_OPERANDS-1 moves the state to DONE.
    - in_val=0 cycles are bubbles: no change to state, acc or count.
    - in_data is ignored when in_val=0.
  - DONE:
    - in_rdy=0, out_val=1, out_sum=acc, out_wrap=wrap.
    - Outputs are held stable until out_rdy=1.
    - On out_val & out_rdy: acc<=0, count<=0, wrap<=0, state<=ACCUM.
- Latency:
  - out_val rises the cycle after the last operand is accepted.
  - in_rdy rises the cycle after the result handshake.
  - No same-cycle bypass between output handshake and input acceptance.
  - Throughput: one group per NUM_OPERANDS+1 cycles at full rate.
- Signal rules:
  - in_rdy and out_val are decoded from state only; neither depends combinationally on in_val or out_rdy.
  - out_sum and out_wrap are 0 whenever out_val=0.
- Widths and arithmetic:
  - count width is $clog2(NUM_OPERANDS).
  - Arithmetic is unsigned; the sum wraps mod 16.
  - out_wrap is sticky across the group.
- in_val asserted while in DONE: no transfer; upstream must hold its data.
- An out_rdy glitch while out_val=0 has no effect.

Decomposition:
- Shared package accumulator_4b_pkg:
  - state enum {ACCUM, DONE}.
  - Localparam for data width (4).
- Natural sub-module: one instance of the existing Adder_4b. Inputs are acc and in_data; its sum feeds the acc register.
- The control FSM and counter stay inline in accumulator_4b.

Test Plan (NUM_OPERANDS=4):
1. Basic sum: operands 1,2,3,4 back-to-back, out_rdy=1 -> out_val=1 one cycle after 4th accept; out_sum=10, out_wrap=0; in_rdy=1 the following cycle.
2. Wrap: operands 8,8,8,9 -> out_sum=1 (33 mod 16), out_wrap=1. Then group 0,0,0,0 -> out_sum=0, out_wrap=0 (flag cleared between groups).
3. Backpressure: group 5,7,0,3 with out_rdy=0 for 5 cycles -> out_val stays 1 with out_sum=15 stable and in_rdy=0. Operand 6 driven with in_val=1 meanwhile is not accepted. Releasing out_rdy completes the handshake; the next group starts from 0.
4. Bubbles: in_val pattern 1,0,1,0,1,1 with data 2,9(ignored),3,9(ignored),4,5 -> out_sum=14, out_val only after the 4th valid transfer.
5. Reset mid-group:
   - Accept 7,7, then pulse rst between clock edges -> in_rdy and out_val go 0 immediately, without waiting for a clock edge.
   - After release, group 1,1,1,1 -> out_sum=4, out_wrap=0.
6. Back-to-back groups: out_rdy tied 1 with in_val continuously 1, operands 15,1,0,0 then 2,2,2,2 -> first result sum=0, wrap=1; second result sum=8, wrap=0. Exactly 5 cycles between out_val pulses.
